// File: rtl/syndrome_pkg.sv
// Shared types and defaults for the fault-dictionary syndrome collector.
package syndrome_pkg;

  localparam int TST_COUNT_DEF = 370;
  localparam int DW_DEF        = 9;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  // "No detection yet" marker for first_det: all ones at the given index width.
  function automatic int unsigned first_none(input int iw);
    return (32'd1 << iw) - 32'd1;
  endfunction

endpackage

// File: rtl/syndrome_collector_if.sv
// Response-pair input channel and syndrome result channel of the collector.
interface syndrome_collector_if #(
  parameter int TST_COUNT = 370,
  parameter int DW        = 9
);
  localparam int IW = $clog2(TST_COUNT);

  logic                 start;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_last;
  logic [DW-1:0]        good_resp;
  logic [DW-1:0]        fault_resp;
  logic                 syn_valid;
  logic                 syn_ready;
  logic [TST_COUNT-1:0] syndrome;
  logic                 detected;
  logic [IW:0]          det_count;
  logic [IW-1:0]        first_det;
  logic [IW:0]          vec_count;
  logic                 overrun;

  modport master (
    output start, resp_valid, resp_last, good_resp, fault_resp, syn_ready,
    input  resp_ready, syn_valid, syndrome, detected, det_count, first_det,
           vec_count, overrun
  );

  modport slave (
    input  start, resp_valid, resp_last, good_resp, fault_resp, syn_ready,
    output resp_ready, syn_valid, syndrome, detected, det_count, first_det,
           vec_count, overrun
  );

endinterface

// File: rtl/syn_index_counter.sv
// Vector counter: count doubles as vec_count, its low bits as the syndrome index.
module syn_index_counter #(
  parameter int TST_COUNT = 370,
  parameter int IW        = $clog2(TST_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [IW:0]   count,
  output logic [IW-1:0] index,
  output logic          terminal
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + (IW+1)'(1);
    end
  end

  assign index    = count[IW-1:0];
  assign terminal = (count == (IW+1)'(TST_COUNT - 1));

endmodule

// File: rtl/syndrome_collector.sv
// Collects one fault's per-vector mismatch bits and detection statistics,
// then offers the result on a valid/ready channel.
module syndrome_collector
  import syndrome_pkg::*;
#(
  parameter int TST_COUNT = TST_COUNT_DEF,
  parameter int DW        = DW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  syndrome_collector_if.slave bus
);

  localparam int IW = $clog2(TST_COUNT);
  localparam logic [IW-1:0] FIRST_NONE = IW'(first_none(IW));

  state_t        state;
  logic          accept;
  logic          clear;
  logic          mismatch;
  logic          terminal;
  logic [IW-1:0] index;
  logic [IW:0]   count;

  // A start pulse while collecting wins over the beat presented in the same cycle.
  assign accept   = (state == COLLECT) && bus.resp_valid && bus.resp_ready && !bus.start;
  assign clear    = bus.start && (state != DONE);
  // Case inequality so X/Z on either response is reported as a detection.
  assign mismatch = (bus.good_resp !== bus.fault_resp);

  syn_index_counter #(
    .TST_COUNT (TST_COUNT),
    .IW        (IW)
  ) u_index (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .inc      (accept),
    .count    (count),
    .index    (index),
    .terminal (terminal)
  );

  assign bus.vec_count = count;
  assign bus.detected  = |bus.syndrome;

  // NOTE: the wide syndrome register is reset so a reset mid-collection leaves no stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.resp_ready <= 1'b0;
      bus.syn_valid  <= 1'b0;
      bus.syndrome   <= '0;
      bus.det_count  <= '0;
      bus.first_det  <= FIRST_NONE;
      bus.overrun    <= 1'b0;
    end else if (clear) begin
      state          <= COLLECT;
      bus.resp_ready <= 1'b1;
      bus.syndrome   <= '0;
      bus.det_count  <= '0;
      bus.first_det  <= FIRST_NONE;
      bus.overrun    <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
            bus.syndrome[index] <= mismatch;
            if (mismatch) begin
              bus.det_count <= bus.det_count + (IW+1)'(1);
              if (bus.first_det == FIRST_NONE) bus.first_det <= index;
            end
            if (bus.resp_last || terminal) begin
              state          <= DONE;
              bus.resp_ready <= 1'b0;
              bus.syn_valid  <= 1'b1;
              bus.overrun    <= !bus.resp_last;
            end
          end
        end
        DONE: begin
          if (bus.syn_ready) begin
            state         <= IDLE;
            bus.syn_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syndrome_collector.sv
// Scoreboard bench for syndrome_collector: a behavioural model predicts each
// fault's result as beats are driven; results are compared when syn_valid rises.
module tb_syndrome_collector;

  localparam int TST = 370;
  localparam int DW  = 9;
  localparam int IW  = $clog2(TST);

  typedef struct packed {
    logic [TST-1:0] syn;
    logic [IW:0]    det;
    logic [IW-1:0]  first;
    logic [IW:0]    vc;
    logic           ovr;
  } result_t;

  logic clk;
  logic rst_n;

  syndrome_collector_if #(.TST_COUNT(TST), .DW(DW)) bus ();

  syndrome_collector #(.TST_COUNT(TST), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  result_t       exp_q[$];
  result_t       m;
  bit            m_done;
  int            checks;
  int            passes;
  logic [IW-1:0] none;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m.syn  = '0;
    m.det  = '0;
    m.first = none;
    m.vc   = '0;
    m.ovr  = 1'b0;
    m_done = 1'b0;
  endtask

  // Drives one beat for one cycle and advances the reference model if the
  // collection for the current fault is still open.
  task automatic drive_beat(input logic [DW-1:0] g, input logic [DW-1:0] f, input logic last);
    int idx;
    bit mm;
    bus.good_resp  = g;
    bus.fault_resp = f;
    bus.resp_last  = last;
    bus.resp_valid = 1'b1;
    if (!m_done) begin
      idx = int'(m.vc);
      mm  = (g !== f);
      m.syn[idx] = mm;
      if (mm) begin
        m.det = m.det + 1;
        if (m.first == none) m.first = idx[IW-1:0];
      end
      m.vc = m.vc + 1;
      if (last || idx == TST - 1) begin
        m_done = 1'b1;
        m.ovr  = !last;
        exp_q.push_back(m);
      end
    end
    tick();
    bus.resp_valid = 1'b0;
    bus.resp_last  = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    model_clear();
    tick();
    bus.start = 1'b0;
    check("ready_after_start", bus.resp_ready, 1);
  endtask

  task automatic cmp_result(input string tag, input result_t e);
    check({tag, "_syndrome"}, bus.syndrome, e.syn);
    check({tag, "_detected"}, bus.detected, |e.syn);
    check({tag, "_det_count"}, bus.det_count, e.det);
    check({tag, "_first_det"}, bus.first_det, e.first);
    check({tag, "_vec_count"}, bus.vec_count, e.vc);
    check({tag, "_overrun"}, bus.overrun, e.ovr);
  endtask

  // Waits (bounded) for syn_valid, checks it against the scoreboard, holds
  // syn_ready low for 'hold' cycles while pushing extra beats, then handshakes.
  task automatic collect_result(input string tag, input int hold, input bit pulse_start);
    int n;
    result_t e;
    n = 0;
    while (bus.syn_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 0);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    cmp_result(tag, e);
    for (int i = 0; i < hold; i++) begin
      bus.good_resp  = 9'h055;
      bus.fault_resp = 9'h0AA;
      bus.resp_valid = 1'b1;
      bus.start      = pulse_start && (i == 2);
      tick();
      bus.start = 1'b0;
      cmp_result({tag, "_hold"}, e);
      check({tag, "_hold_valid"}, bus.syn_valid, 1);
      check({tag, "_hold_ready"}, bus.resp_ready, 0);
    end
    bus.resp_valid = 1'b0;
    bus.syn_ready  = 1'b1;
    tick();
    bus.syn_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.syn_valid, 0);
    check({tag, "_idle_vec_count"}, bus.vec_count, e.vc);
    tick();
    check({tag, "_idle_ready"}, bus.resp_ready, 0);
  endtask

  initial begin
    logic [DW-1:0] g;
    logic [DW-1:0] f;
    int len;
    checks = 0;
    passes = 0;
    none   = '1;
    bus.start      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_last  = 1'b0;
    bus.good_resp  = '0;
    bus.fault_resp = '0;
    bus.syn_ready  = 1'b0;
    model_clear();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_syn_valid", bus.syn_valid, 0);
    check("rst_resp_ready", bus.resp_ready, 0);
    check("rst_syndrome", bus.syndrome, 0);
    check("rst_detected", bus.detected, 0);
    check("rst_det_count", bus.det_count, 0);
    check("rst_first_det", bus.first_det, none);
    check("rst_vec_count", bus.vec_count, 0);
    check("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a collection discards the partial result.
    do_start();
    for (int i = 0; i < 5; i++) drive_beat(9'h001, 9'h002, 1'b0);
    check("mid_vec_count_pre", bus.vec_count, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_syn_valid", bus.syn_valid, 0);
    check("mid_rst_vec_count", bus.vec_count, 0);
    check("mid_rst_first_det", bus.first_det, none);
    check("mid_rst_syndrome", bus.syndrome, 0);
    check("mid_rst_ready", bus.resp_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full test set, no detections.
    do_start();
    for (int i = 0; i < TST; i++) drive_beat(9'h0A5, 9'h0A5, i == TST - 1);
    collect_result("full_clean", 0, 1'b0);

    // Short test set, detections on beats 1 and 3; result held under backpressure.
    do_start();
    for (int i = 0; i < 4; i++)
      drive_beat(9'h010, (i == 1 || i == 3) ? 9'h110 : 9'h010, i == 3);
    check("short_syndrome_const", bus.syndrome, 370'b1010);
    collect_result("short", 10, 1'b0);

    // Overrun: 371 beats without resp_last; start in DONE must be ignored.
    do_start();
    for (int i = 0; i < TST + 1; i++) begin
      if (i == TST) check("overrun_ready_low", bus.resp_ready, 0);
      g = DW'($urandom_range(511));
      f = ($urandom_range(3) == 0) ? g ^ DW'(1 << $urandom_range(8)) : g;
      drive_beat(g, f, 1'b0);
    end
    collect_result("overrun", 4, 1'b1);

    // Restart after 7 beats: the two following beats land at index 0 and 1.
    do_start();
    for (int i = 0; i < 7; i++) drive_beat(9'h0F0, 9'h00F, 1'b0);
    bus.start      = 1'b1;
    bus.resp_valid = 1'b1;
    bus.good_resp  = 9'h111;
    bus.fault_resp = 9'h000;
    model_clear();
    tick();
    bus.start      = 1'b0;
    bus.resp_valid = 1'b0;
    check("restart_vec_count", bus.vec_count, 0);
    check("restart_first_det", bus.first_det, none);
    drive_beat(9'h033, 9'h133, 1'b0);
    drive_beat(9'h044, 9'h044, 1'b1);
    collect_result("restart", 0, 1'b0);

    // A few random-length faults with sparse random detections.
    for (int t = 0; t < 3; t++) begin
      do_start();
      len = $urandom_range(60, 20);
      for (int i = 0; i < len; i++) begin
        g = DW'($urandom_range(511));
        f = ($urandom_range(3) == 0) ? g ^ DW'(1 << $urandom_range(8)) : g;
        drive_beat(g, f, i == len - 1);
      end
      collect_result("random", 2, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/syndrome_collector.md
Name: syndrome_collector

Overview:
- Hardware consumer of good/faulty response pairs for the 8-bit adder-subtractor fault dictionary flow.
- Sits directly downstream of the good/faulty CUT pair.
- For one injected fault, accepts one response pair per test vector, builds the per-vector syndrome bit string (1 = mismatch), and counts detections.
- Presents the finished syndrome through a valid/ready output handshake to the dictionary writer.

Parameters:
- TST_COUNT, 370, maximum test vectors per fault; syndrome width.
- DW, 9, response width (sum plus carry/borrow).
- IW, $clog2(TST_COUNT), vector index width (9 for the default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin collection for a new fault.
- resp_valid  in  1  response pair valid.
- resp_ready  out  1  block accepts response pair.
- resp_last  in  1  qualifies the final vector of the test set.
- good_resp  in  DW  fault-free CUT output.
- fault_resp  in  DW  fault-injected CUT output.
- syn_valid  out  1  syndrome result valid.
- syn_ready  in  1  downstream accepts result.
- syndrome  out  TST_COUNT  bit i = 1 if vector i detected the fault.
- detected  out  1  OR of all syndrome bits.
- det_count  out  IW+1  number of detecting vectors.
- first_det  out  IW  index of first detecting vector; all-ones if none.
- vec_count  out  IW+1  vectors accepted for this fault.
- overrun  out  1  more than TST_COUNT beats arrived without resp_last.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except first_det = all-ones. Reset mid-collection discards the partial syndrome.
- States and transitions:
  - IDLE → COLLECT on start. On entry: syndrome, det_count, vec_count and overrun cleared; first_det set to all-ones; index = 0.
  - COLLECT: resp_ready = 1. Beat = resp_valid && resp_ready.
    - Each beat: syndrome[index] <= (good_resp != fault_resp); index++; vec_count++.
    - On mismatch: det_count++; first_det <= index if first_det is still all-ones.
    - COLLECT → DONE on a beat with resp_last, or on the beat at index TST_COUNT-1.
  - DONE: resp_ready = 0; syn_valid = 1. syndrome, detected, det_count, first_det, vec_count and overrun are held stable. DONE → IDLE when syn_ready = 1 (handshake takes 1 cycle). syn_valid deasserts the next cycle; outputs are held until the next start.
- Latency: the result is valid the cycle after the final beat is accepted.
- Short test set (resp_last before TST_COUNT beats): unused high syndrome bits stay 0.
- Overrun: if the index reaches TST_COUNT-1 without resp_last, the block goes to DONE with overrun = 1. Further resp_valid is not accepted (resp_ready = 0).
- start in COLLECT: restart; clear as on IDLE entry. The beat in the same cycle is dropped.
- start in DONE: ignored until the handshake completes.
- Comparison covers all DW bits; X/Z on the inputs counts as mismatch (case inequality).
- detected is combinational OR of syndrome; all other outputs are registered.

Decomposition:
- Package syndrome_pkg:
  - state enum {IDLE, COLLECT, DONE};
  - default TST_COUNT/DW constants;
  - FIRST_NONE all-ones constant helper.
- Sub-module syn_index_counter: index/vec_count counter with clear, increment and terminal-count flag. Instantiated once.

Test Plan:
- Reset mid-COLLECT after 5 beats → syn_valid=0, vec_count=0, first_det=all-ones, syndrome all 0.
- start, then 370 beats with good=fault=9'h0A5, resp_last on beat 369 → syn_valid one cycle later; detected=0, det_count=0, vec_count=370, overrun=0.
- start, 4 beats with mismatch on beats 1 and 3 (good=9'h010, fault=9'h110), resp_last on beat 3 → syndrome=...0_1010, det_count=2, first_det=1, vec_count=4.
- Hold syn_ready=0 for 10 cycles in DONE while driving resp_valid → outputs stable, resp_ready=0, no beat accepted; syn_ready=1 → IDLE next cycle.
- 371 beats with no resp_last → DONE after beat 369, overrun=1, beat 370 not accepted.
- start asserted at beat 7 of COLLECT → counters cleared; the next 2 beats land at syndrome[0] and syndrome[1].
